// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for the MIPS datapath.
// MULT/MULTU use a shift-add multiply and DIV/DIVU use a restoring divide. Both
// take one iteration per clock over WIDTH clocks. A final fix-up cycle applies
// the result signs and writes HI/LO.
`timescale 1ns/1ps

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    // Control state
    logic [1:0]        state_q,   state_d;
    logic [CW-1:0]     cnt_q,     cnt_d;
    logic              is_div_q,  is_div_d;
    logic              neg_q,     neg_d;      // product / quotient sign
    logic              neg_rem_q, neg_rem_d;  // remainder follows the dividend
    logic              zero_q,    zero_d;     // divisor was zero
    logic [WIDTH-1:0]  a_orig_q,  a_orig_d;   // reported as HI on divide-by-zero
    logic [WIDTH-1:0]  dvsr_q,    dvsr_d;     // |b|: multiplicand or divisor

    // Datapath: {upper W+1 bits, lower W bits}.
    // Multiply: upper holds the running partial product and lower holds the multiplier.
    // Divide: upper holds the partial remainder and lower holds the dividend/quotient.
    logic [2*WIDTH:0]  acc_q,     acc_d;

    // Architectural outputs
    logic [WIDTH-1:0]  hi_q,      hi_d;
    logic [WIDTH-1:0]  lo_q,      lo_d;
    logic              done_q,    done_d;
    logic              dbz_q,     dbz_d;

    // Iteration helpers
    logic              op_signed;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH:0]    mul_upper;
    logic [2*WIDTH:0]  mul_next;
    logic [2*WIDTH:0]  div_shift;
    logic [WIDTH:0]    div_diff;
    logic [2*WIDTH:0]  div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]  quo_fix, rem_fix;

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

    // Operand magnitudes and one shift-add / shift-subtract step
    always_comb begin
        op_signed = ~op[0];
        a_mag     = (op_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag     = (op_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

        mul_upper = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, dvsr_q} : '0);
        mul_next  = {mul_upper, acc_q[WIDTH-1:0]} >> 1;

        div_shift = {acc_q[2*WIDTH-1:0], 1'b0};
        div_diff  = div_shift[2*WIDTH:WIDTH] - {1'b0, dvsr_q};
        div_next  = div_shift;
        if (div_shift[2*WIDTH:WIDTH] >= {1'b0, dvsr_q}) begin
            div_next[2*WIDTH:WIDTH] = div_diff;
            div_next[0]             = 1'b1;
        end

        prod_fix = neg_q ? (~acc_q[2*WIDTH-1:0] + 1'b1) : acc_q[2*WIDTH-1:0];
        quo_fix  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state logic for the IDLE -> CALC -> FIX sequence
    always_comb begin
        // NOTE: every signal gets a hold default first so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        a_orig_d  = a_orig_q;
        dvsr_d    = dvsr_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_div_d  = op[1];
                    neg_d     = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = op_signed & a[WIDTH-1];
                    zero_d    = (b == '0);
                    a_orig_d  = a;
                    dvsr_d    = b_mag;
                    acc_d     = {{(WIDTH+1){1'b0}}, a_mag};
                    cnt_d     = '0;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d  = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d  = prod_fix[WIDTH-1:0];
                    dbz_d = 1'b0;
                end else if (zero_q) begin
                    hi_d  = a_orig_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else begin
                    hi_d  = rem_fix;
                    lo_d  = quo_fix;
                    dbz_d = 1'b0;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous reset that abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            a_orig_q  <= '0;
            dvsr_q    <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            a_orig_q  <= a_orig_d;
            dvsr_q    <= dvsr_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit.
// A transaction-level model predicts busy/done/hi/lo/div_by_zero on every cycle
// from the accepted operations. Directed cases pin that model to literal values.
`timescale 1ns/1ps

module tb_mult_div_unit;

    localparam int WIDTH   = 32;
    localparam int LATENCY = WIDTH + 2;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, div_by_zero;
    logic [WIDTH-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {div_by_zero, hi, lo} computed with plain integer arithmetic
    function automatic logic [64:0] model(input logic [1:0] mop, input logic [31:0] ma,
                                          input logic [31:0] mb);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        logic [31:0] uq, ur;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        case (mop)
            2'b00: begin p = 64'(sa * sb); return {1'b0, p}; end
            2'b01: begin p = {32'b0, ma} * {32'b0, mb}; return {1'b0, p}; end
            default: begin
                if (mb == 32'h0) return {1'b1, ma, 32'hFFFF_FFFF};
                if (mop == 2'b10) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    uq = sq[31:0];
                    ur = sr[31:0];
                end else begin
                    uq = ma / mb;
                    ur = ma % mb;
                end
                return {1'b0, ur, uq};
            end
        endcase
    endfunction

    // Cycle-level model state
    logic        m_busy, m_done, m_dbz;
    logic [31:0] m_hi, m_lo;
    int          m_left;
    logic [64:0] m_pend;
    logic        cap_rst_n, cap_start;
    logic [1:0]  cap_op;
    logic [31:0] cap_a, cap_b;

    initial begin
        m_busy = 0; m_done = 0; m_dbz = 0; m_hi = 0; m_lo = 0; m_left = 0; m_pend = '0;
        cap_rst_n = 0; cap_start = 0; cap_op = 0; cap_a = 0; cap_b = 0;
    end

    // Compare process: advance the model over the last rising edge, then check every output
    always @(negedge clk) begin
        if (!cap_rst_n || !rst_n) begin
            m_busy = 0; m_done = 0; m_dbz = 0; m_hi = 0; m_lo = 0; m_left = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_done = 1;
                    {m_dbz, m_hi, m_lo} = m_pend;
                end
            end else if (cap_start) begin
                m_busy = 1;
                m_left = LATENCY - 1;
                m_pend = model(cap_op, cap_a, cap_b);
            end
        end
        check("mon_busy", 64'(busy), 64'(m_busy));
        check("mon_done", 64'(done), 64'(m_done));
        check("mon_dbz",  64'(div_by_zero), 64'(m_dbz));
        check("mon_hi",   64'(hi), 64'(m_hi));
        check("mon_lo",   64'(lo), 64'(m_lo));
        cap_rst_n = rst_n;
        cap_start = start;
        cap_op    = op;
        cap_a     = a;
        cap_b     = b;
    end

    // Operand generator biased toward boundary values
    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    // Present one start pulse; returns one step past the accepting edge
    task automatic issue(input logic [1:0] iop, input logic [31:0] ia, input logic [31:0] ib);
        start = 1'b1; op = iop; a = ia; b = ib;
        @(posedge clk); #1;
        start = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    // Wait for done; latency counts the accepting edge as 1. Optional spurious starts.
    task automatic wait_done(input bit noise, output int lat);
        lat = 1;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
            if (lat > 3 * LATENCY) begin
                check("done_timeout", 64'(lat), 64'(LATENCY));
                break;
            end
            start = noise && ($urandom_range(0, 7) == 0);
            op = 2'($urandom); a = $urandom; b = $urandom;
        end
        start = 1'b0;
    endtask

    task automatic directed(input string name, input logic [1:0] dop, input logic [31:0] da,
                            input logic [31:0] db, input logic [31:0] ehi,
                            input logic [31:0] elo, input logic edbz);
        int lat;
        issue(dop, da, db);
        wait_done(1'b0, lat);
        check({name, "_lat"}, 64'(lat), 64'(LATENCY));
        check({name, "_hi"},  64'(hi), 64'(ehi));
        check({name, "_lo"},  64'(lo), 64'(elo));
        check({name, "_dbz"}, 64'(div_by_zero), 64'(edbz));
    endtask

    initial begin
        int lat;
        int dones;
        rst_n = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_hilo", {hi, lo}, 64'(0));
        check("rst_dbz",  64'(div_by_zero), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        directed("multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        directed("mult_neg",   2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        directed("div_neg",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        directed("divu_small", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        directed("divu_zero",  2'b11, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        directed("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);

        // Start while busy is ignored; start in the done cycle is accepted
        issue(2'b01, 32'd3, 32'd5);
        lat = 1;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (done || lat > 3 * LATENCY) break;
            start = (lat == 10);
            op = 2'b00; a = 32'd7; b = 32'd9;
        end
        start = 1'b0;
        check("busy_start_lat", 64'(lat), 64'(LATENCY));
        check("busy_start_res", {hi, lo}, 64'd15);
        issue(2'b11, 32'd100, 32'd7);
        check("b2b_busy", 64'(busy), 64'(1));
        wait_done(1'b0, lat);
        check("b2b_lat", 64'(lat), 64'(LATENCY));
        check("b2b_res", {hi, lo}, {32'd2, 32'd14});

        // Asynchronous reset in the middle of an operation
        @(posedge clk); #1;
        issue(2'b11, 32'hDEAD_BEEF, 32'd13);
        repeat (19) @(posedge clk);
        #2;
        check("pre_rst_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_done", 64'(done), 64'(0));
        check("arst_hilo", {hi, lo}, 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        dones = 0;
        repeat (2 * LATENCY) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("arst_no_done", 64'(dones), 64'(0));
        check("arst_idle", 64'(busy), 64'(0));

        // Randomized operations with spurious starts and back-to-back issue
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            issue(2'($urandom), rand_operand(), rand_operand());
            wait_done(1'b1, lat);
            check("rand_lat", 64'(lat), 64'(LATENCY));
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
